// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode valid/ready bundle.
// The master side presents {inst, pc}; the slave side accepts with ready.
interface instruction_fetch_if;
  logic        valid;
  logic [31:0] inst;
  logic [15:0] pc;
  logic        ready;

  modport master (
    output valid,
    output inst,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  inst,
    input  pc,
    output ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// PC and fetch stage feeding a synchronous instruction memory.
// One read in flight, 2-entry FWFT skid FIFO, redirect with flush.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MEM_SIZE = 1201
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [15:0]                imem_addr,
  input  logic [31:0]                imem_rd,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  instruction_fetch_if.master        out,
  output logic                       fetch_stopped
);

  localparam logic [16:0] LIMIT = 17'(MEM_SIZE);

  logic [15:0] addr_q, addr_d;
  logic        infl_q, infl_d;
  logic [15:0] ipc_q, ipc_d;

  logic [31:0] inst_q [2];
  logic [15:0] pc_q [2];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  count_q, count_d;

  logic        deq;
  logic        push;
  logic        in_range;
  logic [2:0]  used;
  logic        issue;

  assign deq      = (count_q != 2'd0) & out.ready;
  assign in_range = {1'b0, addr_q} < LIMIT;
  assign used     = 3'(count_q) + 3'(infl_q)
                  - 3'(deq);
  assign issue    = ~redirect & in_range
                  & (used < 3'd2);
  assign push     = infl_q & ~redirect;

  always_comb begin
    addr_d = addr_q;
    infl_d = 1'b0;
    ipc_d  = ipc_q;
    if (redirect) begin
      addr_d = redirect_pc;
    end else if (issue) begin
      infl_d = 1'b1;
      ipc_d  = addr_q;
      addr_d = addr_q + 16'd1;
    end
  end

  // A flush keeps storage; only pointers and count are cleared.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      wptr_d  = wptr_q ^ push;
      rptr_d  = rptr_q ^ deq;
      count_d = count_q + 2'(push)
              - 2'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= RESET_PC;
      infl_q  <= 1'b0;
      ipc_q   <= 16'h0000;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      addr_q  <= addr_d;
      infl_q  <= infl_d;
      ipc_q   <= ipc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= 32'h0;
        pc_q[i]   <= 16'h0;
      end
    end else if (push) begin
      inst_q[wptr_q] <= imem_rd;
      pc_q[wptr_q]   <= ipc_q;
    end
  end

  assign imem_addr     = addr_q;
  assign out.valid     = count_q != 2'd0;
  assign out.inst      = inst_q[rptr_q];
  assign out.pc        = pc_q[rptr_q];
  assign fetch_stopped = ~in_range & ~infl_q
                       & (count_q == 2'd0);

  // The credit rule must never let a returning word hit a full FIFO.
  a_no_drop: assert property (
    @(posedge clk) disable iff (reset)
    !(push && count_q == 2'd2 && !deq)
  );

  a_count: assert property (
    @(posedge clk) disable iff (reset)
    count_q <= 2'd2
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench: three fetch stages of different MEM_SIZE
// share stimulus and are compared to a queue-based model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [15:0] rpc;
  logic        ready;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned SZ =
      (g == 0) ? 1201 : (g == 1) ? 4 : 65536;
    instruction_fetch_if ifc ();
    logic [15:0] addr;
    logic [31:0] rd;
    logic        stop;

    assign ifc.ready = ready;

    always @(posedge clk)
      rd <= 32'h1000_0000 + {16'h0, addr};

    instruction_fetch #(
      .RESET_PC(16'h0000),
      .MEM_SIZE(SZ)
    ) dut (
      .clk(clk),
      .reset(reset),
      .imem_addr(addr),
      .imem_rd(rd),
      .redirect(redirect),
      .redirect_pc(rpc),
      .out(ifc),
      .fetch_stopped(stop)
    );
  end

  int unsigned msz [3] = '{1201, 4, 65536};
  logic [15:0] mpc [3];
  bit          minf [3];
  logic [15:0] mipc [3];
  logic [47:0] mq [3][$];

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mpc[k]  = 16'h0000;
      minf[k] = 1'b0;
      mipc[k] = 16'h0000;
      mq[k].delete();
    end
  endtask

  task automatic model_step(int k);
    bit deq;
    int used;
    bit iss;
    deq  = (mq[k].size() > 0) && ready;
    used = mq[k].size() + int'(minf[k])
         - int'(deq);
    iss  = !redirect
         && ({16'h0, mpc[k]} < msz[k])
         && (used < 2);
    if (deq) void'(mq[k].pop_front());
    if (redirect) begin
      mq[k].delete();
      minf[k] = 1'b0;
      mpc[k]  = rpc;
    end else begin
      if (minf[k])
        mq[k].push_back({32'h1000_0000
                         + {16'h0, mipc[k]},
                         mipc[k]});
      minf[k] = iss;
      if (iss) begin
        mipc[k] = mpc[k];
        mpc[k]  = mpc[k] + 16'd1;
      end
    end
  endtask

  task automatic check_inst(int k,
                            logic [15:0] a,
                            logic v,
                            logic [31:0] i,
                            logic [15:0] p,
                            logic s);
    bit se;
    se = ({16'h0, mpc[k]} >= msz[k])
       && !minf[k] && (mq[k].size() == 0);
    chk($sformatf("u%0d.valid", k), 64'(v),
        64'(mq[k].size() > 0));
    chk($sformatf("u%0d.addr", k), 64'(a),
        64'(mpc[k]));
    chk($sformatf("u%0d.stopped", k), 64'(s),
        64'(se));
    if (mq[k].size() > 0) begin
      chk($sformatf("u%0d.pc", k), 64'(p),
          64'(mq[k][0][15:0]));
      chk($sformatf("u%0d.inst", k), 64'(i),
          64'(mq[k][0][47:16]));
    end
  endtask

  task automatic check_all();
    check_inst(0, u[0].addr, u[0].ifc.valid,
               u[0].ifc.inst, u[0].ifc.pc,
               u[0].stop);
    check_inst(1, u[1].addr, u[1].ifc.valid,
               u[1].ifc.inst, u[1].ifc.pc,
               u[1].stop);
    check_inst(2, u[2].addr, u[2].ifc.valid,
               u[2].ifc.inst, u[2].ifc.pc,
               u[2].stop);
  endtask

  task automatic check_reset_outs();
    chk("u0.rst_inst", 64'(u[0].ifc.inst), 64'h0);
    chk("u0.rst_pc", 64'(u[0].ifc.pc), 64'h0);
    chk("u1.rst_inst", 64'(u[1].ifc.inst), 64'h0);
    chk("u2.rst_pc", 64'(u[2].ifc.pc), 64'h0);
  endtask

  task automatic cycle(bit r,
                       logic [15:0] t,
                       bit rdy);
    redirect = r;
    rpc      = t;
    ready    = rdy;
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    check_reset_outs();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    logic [15:0] t;
    reset    = 1'b1;
    redirect = 1'b0;
    rpc      = 16'h0;
    ready    = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();
    check_reset_outs();
    reset = 1'b0;

    for (int n = 0; n < 10; n++) cycle(0, 0, 1);

    async_reset();
    for (int n = 0; n < 4; n++) cycle(0, 0, 1);
    for (int n = 0; n < 5; n++) cycle(0, 0, 0);
    for (int n = 0; n < 6; n++) cycle(0, 0, 1);

    for (int n = 0; n < 4; n++) cycle(0, 0, 0);
    cycle(1, 16'h0100, 1);
    for (int n = 0; n < 5; n++) cycle(0, 0, 1);

    cycle(1, 16'h0005, 1);
    cycle(1, 16'h0001, 1);
    for (int n = 0; n < 8; n++) cycle(0, 0, 1);

    cycle(1, 16'hFFFF, 1);
    for (int n = 0; n < 6; n++) cycle(0, 0, 1);
    for (int n = 0; n < 3; n++) cycle(0, 0, 0);
    for (int n = 0; n < 4; n++) cycle(0, 0, 1);

    for (int n = 0; n < 5; n++) cycle(0, 0, 1);
    async_reset();
    for (int n = 0; n < 5; n++) cycle(0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        async_reset();
      end else begin
        case ($urandom_range(3))
          0: t = 16'($urandom_range(7));
          1: t = 16'(1195 + $urandom_range(10));
          2: t = 16'(16'hFFF8
                     + $urandom_range(7));
          default: t = 16'($urandom);
        endcase
        cycle($urandom_range(9) == 0, t,
              $urandom_range(3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
